// File: rtl/vga_timing_core.sv
// vga_timing_core: raster counters, sync, display-enable, pixel tick and
// one-clock event strobes for a parameterised VGA timing generator.
// Optional macro FRAME_COUNT_EN adds the 8-bit frame_count output.
// Every output is registered from the *next* counter values so decodes
// line up with hpos/vpos on the same clock (no extra latency).
module vga_timing_core #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic       vblank_start
`ifdef FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Counters are 10 bits wide and the divider 4 bits wide.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_core: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end
  if (CLK_DIV < 1 || CLK_DIV > 15) begin : g_bad_div
    $error("vga_timing_core: CLK_DIV must be in 1..15");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_DISP_C = 11'(H_DISPLAY);
  localparam logic [10:0] HS_BEG   = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_DISP_C = 11'(V_DISPLAY);
  localparam logic [10:0] VS_BEG   = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic        HS_ACT   = (HSYNC_POL != 0);
  localparam logic        VS_ACT   = (VSYNC_POL != 0);

  logic [3:0]  div;
  logic        adv;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic [10:0] hx;
  logic [10:0] vx;
  logic        col0;
  logic        fs_nxt;

  assign adv    = (div == DIV_LAST);
  assign hx     = {1'b0, h_nxt};
  assign vx     = {1'b0, v_nxt};
  assign col0   = (h_nxt == 10'd0);
  assign fs_nxt = adv && col0 && (v_nxt == 10'd0);

  // Next raster position, assuming this edge is an advance edge.
  always_comb begin
    h_nxt = hpos + 10'd1;
    v_nxt = vpos;
    if (hpos == H_LAST) begin
      h_nxt = 10'd0;
      v_nxt = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    end
  end

  // Divider, counters and all registered decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div          <= 4'd0;
      hpos         <= H_LAST;
      vpos         <= V_LAST;
      pix_tick     <= 1'b0;
      display_on   <= 1'b0;
      hsync        <= ~HS_ACT;
      vsync        <= ~VS_ACT;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      div          <= adv ? 4'd0 : div + 4'd1;
      pix_tick     <= adv;
      // Strobes live only in the tick cycle, so they stay one clk wide.
      line_start   <= adv && col0;
      frame_start  <= fs_nxt;
      vblank_start <= adv && col0 && (vx == V_DISP_C);
      if (adv) begin
        hpos       <= h_nxt;
        vpos       <= v_nxt;
        display_on <= (hx < H_DISP_C) && (vx < V_DISP_C);
        hsync      <= (hx >= HS_BEG && hx < HS_END) ? HS_ACT : ~HS_ACT;
        vsync      <= (vx >= VS_BEG && vx < VS_END) ? VS_ACT : ~VS_ACT;
      end
    end
  end

`ifdef FRAME_COUNT_EN
  logic first_done;

  // Count completed frames; the frame_start right after reset opens frame 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= 8'd0;
      first_done  <= 1'b0;
    end else if (fs_nxt) begin
      if (first_done) frame_count <= frame_count + 8'd1;
      first_done <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench for vga_timing_core: one default-timing instance (a_*),
// one small-raster instance (b_*, 15x11 totals) and the same small raster
// with CLK_DIV=2 and active-high hsync (c_*).
module tb_vga_timing_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  logic       a_tick, a_disp, a_hs, a_vs, a_ls, a_fs, a_vb;
  logic [9:0] a_h, a_v;
  logic       b_tick, b_disp, b_hs, b_vs, b_ls, b_fs, b_vb;
  logic [9:0] b_h, b_v;
  logic       c_tick, c_disp, c_hs, c_vs, c_ls, c_fs, c_vb;
  logic [9:0] c_h, c_v;
`ifdef FRAME_COUNT_EN
  logic [7:0] a_fc, b_fc, c_fc;
`endif

  int   hs_cnt, hs_first, hs_last, ls_cnt;
  int   fs_cnt, last_fs, vb_cnt, vs_low, tick_bad, found;
  int   strobe_bad, hmin, hmax;
  logic prev_vs, prev_ls;
  int   c_hexp [4] = '{14, 0, 0, 1};

  vga_timing_core u_a (
    .clk(clk), .rst(rst_a), .pix_tick(a_tick), .hpos(a_h), .vpos(a_v),
    .display_on(a_disp), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls),
    .frame_start(a_fs), .vblank_start(a_vb)
`ifdef FRAME_COUNT_EN
    , .frame_count(a_fc)
`endif
  );

  vga_timing_core #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) u_b (
    .clk(clk), .rst(rst_b), .pix_tick(b_tick), .hpos(b_h), .vpos(b_v),
    .display_on(b_disp), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls),
    .frame_start(b_fs), .vblank_start(b_vb)
`ifdef FRAME_COUNT_EN
    , .frame_count(b_fc)
`endif
  );

  vga_timing_core #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1), .CLK_DIV(2)
  ) u_c (
    .clk(clk), .rst(rst_c), .pix_tick(c_tick), .hpos(c_h), .vpos(c_v),
    .display_on(c_disp), .hsync(c_hs), .vsync(c_vs), .line_start(c_ls),
    .frame_start(c_fs), .vblank_start(c_vb)
`ifdef FRAME_COUNT_EN
    , .frame_count(c_fc)
`endif
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- default timing: reset and first line ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("a_rst_hpos", int'(a_h), 799);
    check_val("a_rst_vpos", int'(a_v), 524);
    check_val("a_rst_disp", int'(a_disp), 0);
    check_val("a_rst_hsync", int'(a_hs), 1);
    check_val("a_rst_vsync", int'(a_vs), 1);
    check_val("a_rst_tick", int'(a_tick), 0);
    check_val("a_rst_strobes", int'({a_ls, a_fs, a_vb}), 0);
    rst_a = 1'b0;
    @(posedge clk); #1;
    check_val("a_first_hpos", int'(a_h), 0);
    check_val("a_first_vpos", int'(a_v), 0);
    check_val("a_first_fs", int'(a_fs), 1);
    check_val("a_first_ls", int'(a_ls), 1);
    check_val("a_first_disp", int'(a_disp), 1);
    check_val("a_first_hsync", int'(a_hs), 1);
    check_val("a_first_vsync", int'(a_vs), 1);
    check_val("a_first_tick", int'(a_tick), 1);
    hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
    for (int k = 1; k <= 800; k++) begin
      @(posedge clk); #1;
      if (!a_hs) begin
        if (hs_first < 0) hs_first = int'(a_h);
        hs_last = int'(a_h);
        hs_cnt++;
      end
      if (a_ls) ls_cnt++;
      if (a_h == 10'd640) check_val("a_disp_h640", int'(a_disp), 0);
    end
    check_val("a_hsync_len", hs_cnt, 96);
    check_val("a_hsync_first", hs_first, 656);
    check_val("a_hsync_last", hs_last, 751);
    check_val("a_ls_count", ls_cnt, 1);
    check_val("a_line1_hpos", int'(a_h), 0);
    check_val("a_line1_vpos", int'(a_v), 1);
    check_val("a_line1_ls", int'(a_ls), 1);
    check_val("a_line1_fs", int'(a_fs), 0);

    // ---------------- small raster: two frames ----------------
    @(negedge clk);
    rst_b = 1'b0;
    fs_cnt = 0; last_fs = -1; vb_cnt = 0; vs_low = 0; tick_bad = 0; prev_vs = 1'b1;
    for (int t = 0; t <= 330; t++) begin
      @(posedge clk); #1;
      if (b_fs) begin
        fs_cnt++;
        if (last_fs >= 0) check_val("b_frame_gap", t - last_fs, 165);
        else check_val("b_first_fs_t", t, 0);
        last_fs = t;
      end
      if (b_vb) begin
        vb_cnt++;
        check_val("b_vb_vpos", int'(b_v), 6);
        check_val("b_vb_hpos", int'(b_h), 0);
        check_val("b_vb_ls", int'(b_ls), 1);
      end
      if (b_v == 10'd6 && b_h == 10'd0) check_val("b_disp_vblank", int'(b_disp), 0);
      if (!b_vs) vs_low++;
      if (b_vs != prev_vs) check_val("b_vs_edge_hpos", int'(b_h), 0);
      prev_vs = b_vs;
      if (!b_tick) tick_bad++;
    end
    check_val("b_fs_count", fs_cnt, 3);
    check_val("b_vb_count", vb_cnt, 2);
    check_val("b_vsync_low", vs_low, 60);
    check_val("b_tick_gaps", tick_bad, 0);

    // ---------------- small raster: asynchronous reset mid-frame ----------------
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      @(posedge clk); #1;
      if (b_h == 10'd5 && b_v == 10'd3) found = 1;
    end
    check_val("b_seek_found", found, 1);
    check_val("b_pre_rst_disp", int'(b_disp), 1);
    #2 rst_b = 1'b1;
    #1;
    check_val("b_async_hpos", int'(b_h), 14);
    check_val("b_async_vpos", int'(b_v), 10);
    check_val("b_async_disp", int'(b_disp), 0);
    check_val("b_async_hsync", int'(b_hs), 1);
    check_val("b_async_vsync", int'(b_vs), 1);
    check_val("b_async_tick", int'(b_tick), 0);
`ifdef FRAME_COUNT_EN
    check_val("b_async_fc", int'(b_fc), 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk); #1;
    check_val("b_rerun_hpos", int'(b_h), 0);
    check_val("b_rerun_vpos", int'(b_v), 0);
    check_val("b_rerun_fs", int'(b_fs), 1);

`ifdef FRAME_COUNT_EN
    // ---------------- frame counter over 257 frame starts ----------------
    check_val("b_fc_first", int'(b_fc), 0);
    for (int f = 1; f <= 256; f++) begin
      found = 0;
      for (int k = 0; k < 200 && found == 0; k++) begin
        @(posedge clk); #1;
        if (b_fs) found = 1;
      end
      check_val("b_fc_found", found, 1);
      check_val("b_fc_value", int'(b_fc), f % 256);
    end
`endif

    // ---------------- CLK_DIV=2, active-high hsync ----------------
    @(negedge clk);
    check_val("c_rst_hsync", int'(c_hs), 0);
    check_val("c_rst_tick", int'(c_tick), 0);
    rst_c = 1'b0;
    fs_cnt = 0; last_fs = -1; ls_cnt = 0; strobe_bad = 0; tick_bad = 0;
    hs_cnt = 0; hmin = 1000; hmax = -1; prev_ls = 1'b0;
    for (int k = 1; k <= 662; k++) begin
      @(posedge clk); #1;
      if (k <= 4) begin
        check_val("c_tick_seq", int'(c_tick), (k % 2 == 0) ? 1 : 0);
        check_val("c_hpos_seq", int'(c_h), c_hexp[k-1]);
      end
      if (int'(c_tick) != ((k % 2 == 0) ? 1 : 0)) tick_bad++;
      if (c_fs) begin
        fs_cnt++;
        if (last_fs >= 0) check_val("c_frame_gap", k - last_fs, 330);
        else check_val("c_first_fs_k", k, 2);
        last_fs = k;
      end
      if (c_ls) begin
        ls_cnt++;
        if (!c_tick) strobe_bad++;
      end
      if (c_ls && prev_ls) strobe_bad++;
      prev_ls = c_ls;
      if (c_hs) begin
        hs_cnt++;
        if (int'(c_h) < hmin) hmin = int'(c_h);
        if (int'(c_h) > hmax) hmax = int'(c_h);
      end
    end
    check_val("c_fs_count", fs_cnt, 3);
    check_val("c_ls_count", ls_cnt, 23);
    check_val("c_strobe_width", strobe_bad, 0);
    check_val("c_tick_pattern", tick_bad, 0);
    check_val("c_hsync_clks", hs_cnt, 132);
    check_val("c_hsync_hmin", hmin, 10);
    check_val("c_hsync_hmax", hmax, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
